// File: rtl/e203_oitf_pkg.sv
// Shared types and helpers for the outstanding instruction track FIFO.
// Entry payload layout and the wrapping pointer increment live here.
package e203_oitf_pkg;

    localparam int E203_RFIDX_WIDTH = 5;
    localparam int E203_PC_WIDTH    = 32;
    // Widest itag for the largest supported depth (16 entries).
    localparam int PTR_MAX_W        = 4;

    typedef struct packed {
        logic [E203_RFIDX_WIDTH-1:0] rdidx;
        logic                        rdwen;
        logic                        rdfpu;
        logic [E203_PC_WIDTH-1:0]    pc;
    } oitf_entry_t;

    typedef struct packed {
        logic                 flag;
        logic [PTR_MAX_W-1:0] ptr;
    } oitf_ptr_t;

    // Advance a circular pointer; the flag toggles on every wrap so that
    // equal pointers can be told apart as empty (flags equal) or full.
    function automatic oitf_ptr_t ptr_inc(input logic [PTR_MAX_W-1:0] ptr,
                                          input logic                 flag,
                                          input int unsigned          depth);
        oitf_ptr_t res;
        if (32'(ptr) == depth - 32'd1) begin
            res.ptr  = '0;
            res.flag = ~flag;
        end else begin
            res.ptr  = ptr + PTR_MAX_W'(1);
            res.flag = flag;
        end
        return res;
    endfunction

endpackage

// File: rtl/e203_oitf_match.sv
// Compares one dispatch operand against every outstanding destination
// register and raises a hazard flag on any hit.
module e203_oitf_match #(
    parameter int DEPTH   = 2,
    parameter int RFIDX_W = 5
) (
    input  logic [DEPTH-1:0]              vld,
    input  logic [DEPTH-1:0]              rdwen,
    input  logic [DEPTH-1:0]              rdfpu,
    input  logic [DEPTH-1:0][RFIDX_W-1:0] rdidx,
    input  logic [RFIDX_W-1:0]            idx,
    input  logic                          en,
    input  logic                          fpu,
    output logic                          match
);

    logic [DEPTH-1:0] hit;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hit[gi] = vld[gi] & rdwen[gi] & (rdfpu[gi] == fpu) & (rdidx[gi] == idx);
        end
    endgenerate

    assign match = en & (|hit);

endmodule

// File: rtl/e203_exu_oitf_trk.sv
// Outstanding instruction track FIFO: allocates itags at dispatch, exposes
// the oldest entry to write-back and flags RAW/WAW hazards for dispatch.
module e203_exu_oitf_trk
    import e203_oitf_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int ITAG_W  = $clog2(DEPTH),
    parameter int RFIDX_W = 5,
    parameter int PC_W    = 32
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               dis_ena,
    output logic               dis_ready,
    output logic [ITAG_W-1:0]  dis_ptr,
    input  logic [RFIDX_W-1:0] dis_rdidx,
    input  logic               dis_rdwen,
    input  logic               dis_rdfpu,
    input  logic [PC_W-1:0]    dis_pc,

    input  logic               ret_ena,
    output logic [ITAG_W-1:0]  ret_ptr,
    output logic [RFIDX_W-1:0] ret_rdidx,
    output logic               ret_rdwen,
    output logic               ret_rdfpu,
    output logic [PC_W-1:0]    ret_pc,

    output logic               oitf_empty,
    output logic               oitf_full,

    input  logic [RFIDX_W-1:0] disp_rs1idx,
    input  logic [RFIDX_W-1:0] disp_rs2idx,
    input  logic [RFIDX_W-1:0] disp_rs3idx,
    input  logic [RFIDX_W-1:0] disp_rdidx,
    input  logic               disp_rs1en,
    input  logic               disp_rs2en,
    input  logic               disp_rs3en,
    input  logic               disp_rdwen,
    input  logic               disp_rs1fpu,
    input  logic               disp_rs2fpu,
    input  logic               disp_rs3fpu,
    input  logic               disp_rdfpu,
    output logic               oitfrd_match_disprs1,
    output logic               oitfrd_match_disprs2,
    output logic               oitfrd_match_disprs3,
    output logic               oitfrd_match_disprd
);

    logic [ITAG_W-1:0] alc_ptr_reg;
    logic [ITAG_W-1:0] ret_ptr_reg;
    logic              alc_flag_reg;
    logic              ret_flag_reg;
    logic [DEPTH-1:0]  vld_reg;
    logic [DEPTH-1:0]  vld_next;
    oitf_entry_t       entry_reg [DEPTH];

    oitf_ptr_t   alc_inc;
    oitf_ptr_t   ret_inc;
    oitf_entry_t new_entry;
    oitf_entry_t ret_entry;
    logic        ptr_eq;
    logic        dis_acc;
    logic        ret_acc;

    assign alc_inc = ptr_inc(PTR_MAX_W'(alc_ptr_reg), alc_flag_reg, DEPTH);
    assign ret_inc = ptr_inc(PTR_MAX_W'(ret_ptr_reg), ret_flag_reg, DEPTH);

    assign ptr_eq     = (alc_ptr_reg == ret_ptr_reg);
    assign oitf_empty = ptr_eq & (alc_flag_reg == ret_flag_reg);
    assign oitf_full  = ptr_eq & (alc_flag_reg != ret_flag_reg);
    assign dis_ready  = ~oitf_full;

    // Acceptance uses only registered full/empty, so a retire while empty
    // can never pop the entry being written in the same cycle.
    assign dis_acc = dis_ena & ~oitf_full;
    assign ret_acc = ret_ena & ~oitf_empty;

    assign new_entry.rdidx = E203_RFIDX_WIDTH'(dis_rdidx);
    assign new_entry.rdwen = dis_rdwen;
    assign new_entry.rdfpu = dis_rdfpu;
    assign new_entry.pc    = E203_PC_WIDTH'(dis_pc);

    always_comb begin
        vld_next = vld_reg;
        if (dis_acc) begin
            vld_next[alc_ptr_reg] = 1'b1;
        end
        if (ret_acc) begin
            vld_next[ret_ptr_reg] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alc_ptr_reg  <= '0;
            ret_ptr_reg  <= '0;
            alc_flag_reg <= 1'b0;
            ret_flag_reg <= 1'b0;
            vld_reg      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            vld_reg <= vld_next;
            if (dis_acc) begin
                entry_reg[alc_ptr_reg] <= new_entry;
                alc_ptr_reg            <= ITAG_W'(alc_inc.ptr);
                alc_flag_reg           <= alc_inc.flag;
            end
            if (ret_acc) begin
                ret_ptr_reg  <= ITAG_W'(ret_inc.ptr);
                ret_flag_reg <= ret_inc.flag;
            end
        end
    end

    assign dis_ptr   = alc_ptr_reg;
    assign ret_ptr   = ret_ptr_reg;
    assign ret_entry = entry_reg[ret_ptr_reg];
    assign ret_rdidx = RFIDX_W'(ret_entry.rdidx);
    assign ret_rdwen = ret_entry.rdwen;
    assign ret_rdfpu = ret_entry.rdfpu;
    assign ret_pc    = PC_W'(ret_entry.pc);

    // Flattened entry view shared by the four operand comparators.
    logic [DEPTH-1:0]              ent_rdwen;
    logic [DEPTH-1:0]              ent_rdfpu;
    logic [DEPTH-1:0][RFIDX_W-1:0] ent_rdidx;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
            assign ent_rdwen[gi] = entry_reg[gi].rdwen;
            assign ent_rdfpu[gi] = entry_reg[gi].rdfpu;
            assign ent_rdidx[gi] = RFIDX_W'(entry_reg[gi].rdidx);
        end
    endgenerate

    logic [3:0][RFIDX_W-1:0] op_idx;
    logic [3:0]              op_en;
    logic [3:0]              op_fpu;
    logic [3:0]              op_match;

    assign op_idx = {disp_rdidx, disp_rs3idx, disp_rs2idx, disp_rs1idx};
    assign op_en  = {disp_rdwen, disp_rs3en,  disp_rs2en,  disp_rs1en};
    assign op_fpu = {disp_rdfpu, disp_rs3fpu, disp_rs2fpu, disp_rs1fpu};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_match
            e203_oitf_match #(
                .DEPTH   (DEPTH),
                .RFIDX_W (RFIDX_W)
            ) u_match (
                .vld   (vld_reg),
                .rdwen (ent_rdwen),
                .rdfpu (ent_rdfpu),
                .rdidx (ent_rdidx),
                .idx   (op_idx[gi]),
                .en    (op_en[gi]),
                .fpu   (op_fpu[gi]),
                .match (op_match[gi])
            );
        end
    endgenerate

    assign oitfrd_match_disprs1 = op_match[0];
    assign oitfrd_match_disprs2 = op_match[1];
    assign oitfrd_match_disprs3 = op_match[2];
    assign oitfrd_match_disprd  = op_match[3];

endmodule

// File: tb/tb_e203_exu_oitf_trk.sv
// Drives a 2-entry and a 3-entry tracker with identical stimulus and checks
// both against a counter/array reference model of the FIFO rules.
module tb_e203_exu_oitf_trk;

    logic        clk = 1'b0;
    logic        rst;
    logic        dis_ena, ret_ena;
    logic [4:0]  dis_rdidx;
    logic        dis_rdwen, dis_rdfpu;
    logic [31:0] dis_pc;
    logic [4:0]  s1_idx, s2_idx, s3_idx, sd_idx;
    logic        s1_en, s2_en, s3_en, sd_en;
    logic        s1_fpu, s2_fpu, s3_fpu, sd_fpu;

    always #5 clk = ~clk;

    logic        d2_ready, d2_rdwen, d2_rdfpu, d2_empty, d2_full;
    logic        d2_m1, d2_m2, d2_m3, d2_md;
    logic [0:0]  d2_dptr, d2_rptr;
    logic [4:0]  d2_rdidx;
    logic [31:0] d2_pc;

    logic        d3_ready, d3_rdwen, d3_rdfpu, d3_empty, d3_full;
    logic        d3_m1, d3_m2, d3_m3, d3_md;
    logic [1:0]  d3_dptr, d3_rptr;
    logic [4:0]  d3_rdidx;
    logic [31:0] d3_pc;

    e203_exu_oitf_trk #(.DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .dis_ena(dis_ena), .dis_ready(d2_ready), .dis_ptr(d2_dptr),
        .dis_rdidx(dis_rdidx), .dis_rdwen(dis_rdwen), .dis_rdfpu(dis_rdfpu), .dis_pc(dis_pc),
        .ret_ena(ret_ena), .ret_ptr(d2_rptr), .ret_rdidx(d2_rdidx),
        .ret_rdwen(d2_rdwen), .ret_rdfpu(d2_rdfpu), .ret_pc(d2_pc),
        .oitf_empty(d2_empty), .oitf_full(d2_full),
        .disp_rs1idx(s1_idx), .disp_rs2idx(s2_idx), .disp_rs3idx(s3_idx), .disp_rdidx(sd_idx),
        .disp_rs1en(s1_en), .disp_rs2en(s2_en), .disp_rs3en(s3_en), .disp_rdwen(sd_en),
        .disp_rs1fpu(s1_fpu), .disp_rs2fpu(s2_fpu), .disp_rs3fpu(s3_fpu), .disp_rdfpu(sd_fpu),
        .oitfrd_match_disprs1(d2_m1), .oitfrd_match_disprs2(d2_m2),
        .oitfrd_match_disprs3(d2_m3), .oitfrd_match_disprd(d2_md)
    );

    e203_exu_oitf_trk #(.DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .dis_ena(dis_ena), .dis_ready(d3_ready), .dis_ptr(d3_dptr),
        .dis_rdidx(dis_rdidx), .dis_rdwen(dis_rdwen), .dis_rdfpu(dis_rdfpu), .dis_pc(dis_pc),
        .ret_ena(ret_ena), .ret_ptr(d3_rptr), .ret_rdidx(d3_rdidx),
        .ret_rdwen(d3_rdwen), .ret_rdfpu(d3_rdfpu), .ret_pc(d3_pc),
        .oitf_empty(d3_empty), .oitf_full(d3_full),
        .disp_rs1idx(s1_idx), .disp_rs2idx(s2_idx), .disp_rs3idx(s3_idx), .disp_rdidx(sd_idx),
        .disp_rs1en(s1_en), .disp_rs2en(s2_en), .disp_rs3en(s3_en), .disp_rdwen(sd_en),
        .disp_rs1fpu(s1_fpu), .disp_rs2fpu(s2_fpu), .disp_rs3fpu(s3_fpu), .disp_rdfpu(sd_fpu),
        .oitfrd_match_disprs1(d3_m1), .oitfrd_match_disprs2(d3_m2),
        .oitfrd_match_disprs3(d3_m3), .oitfrd_match_disprd(d3_md)
    );

    // Reference model: free-running allocate/retire counts; itag = count mod depth.
    typedef struct {
        int rdidx;
        int rdwen;
        int rdfpu;
        int pc;
    } ment_t;

    ment_t mem [2][3];
    int    alc_cnt [2];
    int    ret_cnt [2];
    int    dep [2] = '{2, 3};
    int    n_chk  = 0;
    int    n_pass = 0;
    int    cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int exp_match(input int i, input logic en, input logic fpu, input logic [4:0] idx);
        ment_t e;
        if (!en) return 0;
        for (int k = ret_cnt[i]; k < alc_cnt[i]; k++) begin
            e = mem[i][k % dep[i]];
            if (e.rdwen == 1 && e.rdfpu == int'(fpu) && e.rdidx == int'(idx)) return 1;
        end
        return 0;
    endfunction

    task automatic check_dut(input int i,
                             input logic [31:0] empty, input logic [31:0] full, input logic [31:0] ready,
                             input logic [31:0] dptr, input logic [31:0] rptr,
                             input logic [31:0] rdidx, input logic [31:0] rdwen, input logic [31:0] rdfpu,
                             input logic [31:0] pc,
                             input logic [31:0] m1, input logic [31:0] m2, input logic [31:0] m3,
                             input logic [31:0] md);
        int    occ;
        ment_t h;
        string p;
        occ = alc_cnt[i] - ret_cnt[i];
        h   = mem[i][ret_cnt[i] % dep[i]];
        p   = $sformatf("d%0d_", dep[i]);
        chk({p, "empty"}, empty, (occ == 0) ? 1 : 0);
        chk({p, "full"}, full, (occ == dep[i]) ? 1 : 0);
        chk({p, "ready"}, ready, (occ == dep[i]) ? 0 : 1);
        chk({p, "dis_ptr"}, dptr, alc_cnt[i] % dep[i]);
        chk({p, "ret_ptr"}, rptr, ret_cnt[i] % dep[i]);
        chk({p, "ret_rdidx"}, rdidx, h.rdidx);
        chk({p, "ret_rdwen"}, rdwen, h.rdwen);
        chk({p, "ret_rdfpu"}, rdfpu, h.rdfpu);
        chk({p, "ret_pc"}, pc, h.pc);
        chk({p, "match_rs1"}, m1, exp_match(i, s1_en, s1_fpu, s1_idx));
        chk({p, "match_rs2"}, m2, exp_match(i, s2_en, s2_fpu, s2_idx));
        chk({p, "match_rs3"}, m3, exp_match(i, s3_en, s3_fpu, s3_idx));
        chk({p, "match_rd"}, md, exp_match(i, sd_en, sd_fpu, sd_idx));
    endtask

    task automatic check_all();
        check_dut(0, 32'(d2_empty), 32'(d2_full), 32'(d2_ready), 32'(d2_dptr), 32'(d2_rptr),
                  32'(d2_rdidx), 32'(d2_rdwen), 32'(d2_rdfpu), d2_pc,
                  32'(d2_m1), 32'(d2_m2), 32'(d2_m3), 32'(d2_md));
        check_dut(1, 32'(d3_empty), 32'(d3_full), 32'(d3_ready), 32'(d3_dptr), 32'(d3_rptr),
                  32'(d3_rdidx), 32'(d3_rdwen), 32'(d3_rdfpu), d3_pc,
                  32'(d3_m1), 32'(d3_m2), 32'(d3_m3), 32'(d3_md));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            alc_cnt[i] = 0;
            ret_cnt[i] = 0;
            for (int k = 0; k < 3; k++) mem[i][k] = '{0, 0, 0, 0};
        end
    endtask

    // One clock: drive, check pre-edge outputs, advance the model at the edge.
    task automatic cycle(input bit r, input bit d, input bit t,
                         input int rd, input bit wen, input bit fpu, input int pc);
        int occ;
        rst       = r;
        dis_ena   = d;
        ret_ena   = t;
        dis_rdidx = rd[4:0];
        dis_rdwen = wen;
        dis_rdfpu = fpu;
        dis_pc    = pc;
        #1;
        check_all();
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                occ = alc_cnt[i] - ret_cnt[i];
                if (d && occ < dep[i]) begin
                    mem[i][alc_cnt[i] % dep[i]] = '{rd & 31, int'(wen), int'(fpu), pc};
                    alc_cnt[i]++;
                end
                if (t && occ > 0) ret_cnt[i]++;
            end
        end
        @(negedge clk);
        $display("cyc %0d rst=%0b dis=%0b ret=%0b rd=%0d pc=%h occ2=%0d occ3=%0d",
                 cyc, r, d, t, rd, pc, alc_cnt[0] - ret_cnt[0], alc_cnt[1] - ret_cnt[1]);
        cyc++;
    endtask

    task automatic clear_disp();
        {s1_idx, s2_idx, s3_idx, sd_idx} = '0;
        {s1_en, s2_en, s3_en, sd_en}     = '0;
        {s1_fpu, s2_fpu, s3_fpu, sd_fpu} = '0;
    endtask

    task automatic rand_disp();
        s1_idx = 5'($urandom_range(0, 3)); s1_en = 1'($urandom); s1_fpu = 1'($urandom);
        s2_idx = 5'($urandom_range(0, 3)); s2_en = 1'($urandom); s2_fpu = 1'($urandom);
        s3_idx = 5'($urandom_range(0, 3)); s3_en = 1'($urandom); s3_fpu = 1'($urandom);
        sd_idx = 5'($urandom_range(0, 3)); sd_en = 1'($urandom); sd_fpu = 1'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seq [7] = '{0, 1, 2, 0, 1, 2, 0};
        rst = 1'b1; dis_ena = 1'b0; ret_ena = 1'b0;
        dis_rdidx = '0; dis_rdwen = 1'b0; dis_rdfpu = 1'b0; dis_pc = '0;
        clear_disp();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset then idle
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("rst_empty", 32'(d2_empty), 1);
        chk("rst_dis_ptr", 32'(d2_dptr), 0);
        chk("rst_ret_pc", d2_pc, 0);

        // Fill the 2-entry tracker, then an ignored third dispatch
        chk("fill_ptr0", 32'(d2_dptr), 0);
        cycle(0, 1, 0, 5, 1, 0, 'h100);
        chk("fill_ptr1", 32'(d2_dptr), 1);
        cycle(0, 1, 0, 6, 1, 0, 'h104);
        chk("fill_full", 32'(d2_full), 1);
        chk("fill_rdidx", 32'(d2_rdidx), 5);
        chk("fill_pc", d2_pc, 'h100);
        cycle(0, 1, 0, 7, 1, 0, 'h108);
        chk("ovf_full", 32'(d2_full), 1);
        chk("ovf_pc", d2_pc, 'h100);
        chk("ovf_ptr", 32'(d2_dptr), 0);

        // Drain, then retire while empty
        cycle(0, 0, 1, 0, 0, 0, 0);
        chk("drain_pc", d2_pc, 'h104);
        cycle(0, 0, 1, 0, 0, 0, 0);
        chk("drain_empty", 32'(d2_empty), 1);
        cycle(0, 0, 1, 0, 0, 0, 0);
        chk("udf_ret_ptr", 32'(d2_rptr), 0);
        chk("udf_dis_ptr", 32'(d2_dptr), 0);
        chk("udf_empty", 32'(d2_empty), 1);

        // Wrap on the 3-entry tracker
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 7; n++) begin
            chk("wrap_dis_ptr", 32'(d3_dptr), seq[n]);
            cycle(0, 1, 0, n, 1, 0, 'h200 + 4 * n);
            chk("wrap_not_empty", 32'(d3_empty), 0);
            chk("wrap_not_full", 32'(d3_full), 0);
            cycle(0, 0, 1, 0, 0, 0, 0);
            chk("wrap_empty", 32'(d3_empty), 1);
        end

        // Simultaneous dispatch and retire while full, then while empty
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 1, 1, 0, 'h300);
        cycle(0, 1, 0, 2, 1, 0, 'h304);
        cycle(0, 1, 1, 3, 1, 0, 'h308);
        chk("full_both_full", 32'(d2_full), 0);
        chk("full_both_ret_ptr", 32'(d2_rptr), 1);
        chk("full_both_dis_ptr", 32'(d2_dptr), 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 9, 1, 1, 'h400);
        chk("empty_both_empty", 32'(d2_empty), 0);
        chk("empty_both_rdidx", 32'(d2_rdidx), 9);

        // Hazard matching against an outstanding rd = x10
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 10, 1, 0, 'h500);
        s2_idx = 5'd10; s2_en = 1'b1; s2_fpu = 1'b0;
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("haz_rs2_hit", 32'(d2_m2), 1);
        s2_fpu = 1'b1;
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("haz_rs2_fpu", 32'(d2_m2), 0);
        s2_fpu = 1'b0; s2_en = 1'b0;
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("haz_rs2_en", 32'(d2_m2), 0);
        cycle(0, 1, 0, 12, 0, 0, 'h504);
        s1_idx = 5'd12; s1_en = 1'b1; s1_fpu = 1'b0;
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("haz_nowen", 32'(d2_m1), 0);
        sd_idx = 5'd10; sd_en = 1'b1; sd_fpu = 1'b0;
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("haz_rd_waw", 32'(d2_md), 1);
        clear_disp();

        // Randomized traffic with occasional mid-run reset
        for (int n = 0; n < 400; n++) begin
            rand_disp();
            cycle(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), int'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
